uart_tx_buffer: RTL and testbench

Byte buffer and launch controller directly upstream of the UART transmitter. It accepts bytes from a host-side write port into a small circular FIFO. It hands them one at a time to the transmitter using the transmitter's `tx_start`/`din`/`tx_done_tick` handshake, keeping the line busy back-to-back while data remains. It decouples bursty producers from the 16×-oversampled serial rate.

---
 rtl/uart_pkg.sv | 6 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/uart_tx_buffer.sv | 60 ++++++
 tb/tb_uart_tx_buffer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and defaults for the transmitter, baud generator and tx buffer.
// Contents: UART_DBIT (default data width), buf_state_t (tx buffer launch FSM states).
package uart_pkg;
  localparam int UART_DBIT = 8;
  typedef enum logic [1:0] {IDLE, START, BUSY} buf_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular FIFO with an occupancy counter, synchronous flush and an overflow pulse.
// Ports: clk, reset_n (async active-low); wr_en/wr_data push port; rd_en pop port with
// combinational rd_data = mem[rd_ptr]; flush clears pointers and count; full, empty and count
// report occupancy; overflow pulses the cycle after a write that arrived while full.
module sync_fifo #(
  parameter int DBIT = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DBIT-1:0]       wr_data,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic [DBIT-1:0]       rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [DBIT-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  // push is judged against the pre-pop full flag, so a write while full is dropped even on a pop cycle
  assign push = wr_en & ~full & ~flush;
  assign pop = rd_en & ~empty & ~flush;
  assign full = count == (DEPTH_LOG2+1)'(DEPTH);
  assign empty = count == '0;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en & full;
      wr_ptr <= flush ? '0 : wr_ptr + DEPTH_LOG2'(push);
      rd_ptr <= flush ? '0 : rd_ptr + DEPTH_LOG2'(pop);
      count <= flush ? '0 : count + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    end
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO plus launch FSM feeding a UART transmitter via tx_start/din/tx_done_tick.
// Ports: clk, reset_n (async active-low); wr_en/wr_data host write port; flush clears the queue
// without aborting the byte in flight; full/empty/count/overflow FIFO status; tx_busy high in
// START or BUSY; tx_start one-cycle launch pulse; din byte held for the transmitter;
// tx_done_tick completion pulse from the transmitter.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DBIT = UART_DBIT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DBIT-1:0]       wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_busy,
  output logic                  tx_start,
  output logic [DBIT-1:0]       din,
  input  logic                  tx_done_tick
);
  buf_state_t state;
  logic launch;
  logic [DBIT-1:0] rd_data;
  assign launch = (state == IDLE) & ~empty & ~flush;
  assign tx_start = state == START;
  assign tx_busy = state != IDLE;
  sync_fifo #(.DBIT(DBIT), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_en(launch),
    .flush(flush),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      din <= '0;
    end else begin
      case (state)
        IDLE: if (launch) begin
          din <= rd_data;
          state <= START;
        end
        START: state <= BUSY;
        BUSY: if (tx_done_tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed self-checking bench with a behavioural transmitter done-tick model.
module tb_uart_tx_buffer;
  logic clk = 1'b0;
  logic reset_n, wr_en, flush, tx_done_tick;
  logic [7:0] wr_data;
  logic full, empty, overflow, tx_busy, tx_start;
  logic [4:0] count;
  logic [7:0] din;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame = 20;
  int model_cnt = 0;
  logic [7:0] launched[$];
  int start_cyc[$];

  uart_tx_buffer dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .tx_busy(tx_busy),
    .tx_start(tx_start), .din(din), .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (tx_start) begin
      launched.push_back(din);
      start_cyc.push_back(cyc);
    end

  // transmitter stand-in: done tick arrives 'frame' cycles after the START cycle
  initial begin
    tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      tx_done_tick = 1'b0;
      if (!reset_n) model_cnt = 0;
      else if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) tx_done_tick = 1'b1;
      end else if (tx_start) model_cnt = frame;
    end
  end

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (empty && !tx_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bit ok;
    int n;
    reset_n = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({count, empty, full, tx_busy, tx_start, din, overflow} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_init count=%0d empty=%b full=%b busy=%b start=%b din=%h ovf=%b expected 0 1 0 0 0 00 0",
               count, empty, full, tx_busy, tx_start, din, overflow);
    end
    reset_n = 1'b1;
    @(negedge clk);
    frame = 10;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (2) @(negedge clk);
    checks++;
    if (tx_busy !== 1'b1 || count !== 5'd2) begin
      errors++;
      $display("FAIL reset_prestream busy=%b count=%0d expected 1 2", tx_busy, count);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({count, empty, full, tx_busy, tx_start, din, overflow} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid count=%0d empty=%b full=%b busy=%b start=%b din=%h ovf=%b expected 0 1 0 0 0 00 0",
               count, empty, full, tx_busy, tx_start, din, overflow);
    end
    @(negedge clk);
    reset_n = 1'b1;
    n = launched.size();
    repeat (20) @(negedge clk);
    checks++;
    if (launched.size() !== n || empty !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_start launches=%0d empty=%b busy=%b expected %0d 1 0", launched.size(), empty, tx_busy, n);
    end
    wait_idle(10, ok);
  endtask

  task automatic test_single;
    bit ok;
    frame = 20;
    launched.delete();
    push(8'hA5);
    checks++;
    if (empty !== 1'b0 || count !== 5'd1 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL single_push empty=%b count=%0d start=%b expected 0 1 0", empty, count, tx_start);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || din !== 8'hA5 || count !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL single_launch start=%b din=%h count=%0d empty=%b expected 1 a5 0 1", tx_start, din, count, empty);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || tx_busy !== 1'b1 || din !== 8'hA5) begin
      errors++;
      $display("FAIL single_busy start=%b busy=%b din=%h expected 0 1 a5", tx_start, tx_busy, din);
    end
    wait_idle(100, ok);
    checks++;
    if (!ok || launched.size() !== 1) begin
      errors++;
      $display("FAIL single_done idle=%b launches=%0d expected 1 1", ok, launched.size());
    end
  endtask

  task automatic test_burst;
    bit ok;
    int bad_full = 0;
    frame = 20;
    launched.delete();
    start_cyc.delete();
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      if (full !== (count == 5'd16)) bad_full++;
    end
    checks++;
    if (count !== 5'd15 || full !== 1'b0) begin
      errors++;
      $display("FAIL burst_count count=%0d full=%b expected 15 0", count, full);
    end
    wait_idle(600, ok);
    checks++;
    if (!ok || bad_full != 0) begin
      errors++;
      $display("FAIL burst_drain idle=%b full_mismatches=%0d expected 1 0", ok, bad_full);
    end
    checks++;
    if (launched.size() !== 16) begin
      errors++;
      $display("FAIL burst_len launches=%0d expected 16", launched.size());
    end else
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (launched[i] !== 8'(i + 1)) begin
          errors++;
          $display("FAIL burst_order idx=%0d din=%h expected %h", i, launched[i], 8'(i + 1));
        end
        if (i > 0) begin
          checks++;
          if (start_cyc[i] - start_cyc[i-1] != 22) begin
            errors++;
            $display("FAIL burst_gap idx=%0d gap=%0d expected 22", i, start_cyc[i] - start_cyc[i-1]);
          end
        end
      end
  endtask

  task automatic test_overflow;
    bit ok;
    bit saw_ee = 1'b0;
    frame = 200;
    launched.delete();
    push(8'h30);
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    checks++;
    if (count !== 5'd16 || full !== 1'b1 || tx_busy !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_fill count=%0d full=%b busy=%b ovf=%b expected 16 1 1 0", count, full, tx_busy, overflow);
    end
    push(8'hEE);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL ovf_pulse ovf=%b count=%0d expected 1 16", overflow, count);
    end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear ovf=%b full=%b expected 0 1", overflow, full);
    end
    frame = 5;
    wait_idle(800, ok);
    foreach (launched[i]) if (launched[i] === 8'hEE) saw_ee = 1'b1;
    checks++;
    if (!ok || launched.size() !== 17 || saw_ee) begin
      errors++;
      $display("FAIL ovf_drain idle=%b launches=%0d saw_ee=%b expected 1 17 0", ok, launched.size(), saw_ee);
    end else
      for (int i = 1; i < 17; i++) begin
        checks++;
        if (launched[i] !== 8'h40 + 8'(i - 1)) begin
          errors++;
          $display("FAIL ovf_order idx=%0d din=%h expected %h", i, launched[i], 8'h40 + 8'(i - 1));
        end
      end
  endtask

  task automatic test_simultaneous;
    bit ok;
    int waited = 0;
    int full_waits = 0;
    logic [7:0] exp_q[$];
    frame = 30;
    launched.delete();
    for (int i = 0; i < 4; i++) begin
      push(8'h60 + 8'(i));
      exp_q.push_back(8'h60 + 8'(i));
    end
    checks++;
    if (count !== 5'd3) begin
      errors++;
      $display("FAIL simul_pre count=%0d expected 3", count);
    end
    while (tx_busy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (tx_busy !== 1'b0 || count !== 5'd3) begin
      errors++;
      $display("FAIL simul_idle busy=%b count=%0d expected 0 3", tx_busy, count);
    end
    push(8'h64);
    exp_q.push_back(8'h64);
    checks++;
    if (count !== 5'd3 || tx_start !== 1'b1 || din !== 8'h61) begin
      errors++;
      $display("FAIL simul_pushpop count=%0d start=%b din=%h expected 3 1 61", count, tx_start, din);
    end
    frame = 3;
    for (int i = 0; i < 40; i++) begin
      while (full && full_waits < 2000) begin
        @(negedge clk);
        full_waits++;
      end
      push(8'h80 + 8'(i));
      exp_q.push_back(8'h80 + 8'(i));
    end
    wait_idle(1000, ok);
    checks++;
    if (!ok || launched.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL simul_drain idle=%b launches=%0d expected 1 %0d", ok, launched.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (launched[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL simul_order idx=%0d din=%h expected %h", i, launched[i], exp_q[i]);
        end
      end
  endtask

  task automatic test_flush;
    bit ok;
    frame = 40;
    launched.delete();
    push(8'h70);
    for (int i = 1; i <= 5; i++) push(8'h70 + 8'(i));
    checks++;
    if (count !== 5'd5 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre count=%0d busy=%b expected 5 1", count, tx_busy);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || tx_busy !== 1'b1 || din !== 8'h70) begin
      errors++;
      $display("FAIL flush_clear count=%0d empty=%b busy=%b din=%h expected 0 1 1 70", count, empty, tx_busy, din);
    end
    wait_idle(100, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || launched.size() !== 1 || launched[0] !== 8'h70) begin
      errors++;
      $display("FAIL flush_after idle=%b launches=%0d first=%h expected 1 1 70", ok, launched.size(),
               launched.size() > 0 ? launched[0] : 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
